// File: rtl/fetch_unit_if.sv
// Handshake/bus bundle between fetch_unit, the instruction ROM and the consumer.
// The slave modport is the fetch unit's view; master is the environment's view.
interface fetch_unit_if #(
    parameter int ADDR_W = 7,
    parameter int INST_W = 16
);
    logic              Fetch_En;
    logic              Inst_Ack;
    logic              PC_Ld;
    logic [ADDR_W-1:0] Jmp_Addr;
    logic [INST_W-1:0] Mem_Data;
    logic [ADDR_W-1:0] Mem_Addr;
    logic [INST_W-1:0] Inst_Out;
    logic [ADDR_W-1:0] Inst_PC;
    logic              Inst_Valid;
    logic              PC_Wrap;

    modport slave (
        input  Fetch_En, Inst_Ack, PC_Ld, Jmp_Addr, Mem_Data,
        output Mem_Addr, Inst_Out, Inst_PC, Inst_Valid, PC_Wrap
    );

    modport master (
        output Fetch_En, Inst_Ack, PC_Ld, Jmp_Addr, Mem_Data,
        input  Mem_Addr, Inst_Out, Inst_PC, Inst_Valid, PC_Wrap
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE/ISSUE/CAPTURE/HOLD sequencer over a 1-cycle ROM.
// Jump support (PC_Ld/Jmp_Addr) is compiled in only when FETCH_JUMP_EN is defined.
module fetch_unit #(
    parameter int          ADDR_W   = 7,
    parameter int          INST_W   = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic          Clk,
    input  logic          PC_Clr,
    fetch_unit_if.slave   bus
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] HOLD    = 2'd3;

    localparam logic [ADDR_W-1:0] RESET_PC_V = RESET_PC[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] PC_MAX     = {ADDR_W{1'b1}};

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic              valid_q, valid_d;
    logic              wrap_q, wrap_d;
    logic              jump_s;
    logic [ADDR_W-1:0] jmp_addr_s;

`ifdef FETCH_JUMP_EN
    assign jump_s     = bus.PC_Ld;
    assign jmp_addr_s = bus.Jmp_Addr;
`else
    // Jump inputs stay on the port list but never reach the datapath.
    logic unused_jump_s;
    assign unused_jump_s = ^{bus.PC_Ld, bus.Jmp_Addr};
    assign jump_s        = 1'b0;
    assign jmp_addr_s    = {ADDR_W{1'b0}};
`endif

    // Next-state logic; a jump overrides the sequencer and drops any in-flight fetch.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        valid_d   = valid_q;
        wrap_d    = wrap_q;
        if (jump_s) begin
            pc_d    = jmp_addr_s;
            valid_d = 1'b0;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.Fetch_En) begin
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
                ISSUE: begin
                    state_d = CAPTURE;
                end
                CAPTURE: begin
                    inst_d    = bus.Mem_Data;
                    inst_pc_d = pc_q;
                    pc_d      = pc_q + ADDR_W'(1);
                    valid_d   = 1'b1;
                    state_d   = HOLD;
                    if (pc_q == PC_MAX) begin
                        wrap_d = 1'b1;
                    end else begin
                        wrap_d = wrap_q;
                    end
                end
                HOLD: begin
                    if (bus.Inst_Ack) begin
                        valid_d = 1'b0;
                        if (bus.Fetch_En) begin
                            state_d = ISSUE;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State registers with synchronous clear taking priority over everything.
    always_ff @(posedge Clk) begin
        if (PC_Clr) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC_V;
            inst_q    <= {INST_W{1'b0}};
            inst_pc_q <= {ADDR_W{1'b0}};
            valid_q   <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            valid_q   <= valid_d;
            wrap_q    <= wrap_d;
        end
    end

    assign bus.Mem_Addr   = pc_q;
    assign bus.Inst_Out   = inst_q;
    assign bus.Inst_PC    = inst_pc_q;
    assign bus.Inst_Valid = valid_q;
    assign bus.PC_Wrap    = wrap_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised and directed bench for fetch_unit against a cycle-level reference model.
// Expectations for PC_Ld follow whether FETCH_JUMP_EN is defined for the build.
module tb_fetch_unit;

    localparam int AW = 7;
    localparam int IW = 16;

    logic Clk;
    logic PC_Clr;
    int   vec;
    int   err;

    fetch_unit_if #(.ADDR_W(AW), .INST_W(IW)) bus ();

    fetch_unit #(.ADDR_W(AW), .INST_W(IW), .RESET_PC(0)) dut (
        .Clk    (Clk),
        .PC_Clr (PC_Clr),
        .bus    (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ROM: data is 0x0100 plus the address presented in the previous cycle.
    always @(posedge Clk) bus.Mem_Data <= 16'h0100 + 16'(bus.Mem_Addr);

    // Reference model: m_rem counts edges left until the pending capture (0 = none).
    logic [AW-1:0] m_pc;
    logic [IW-1:0] m_ir;
    logic [AW-1:0] m_irpc;
    logic          m_valid;
    logic          m_wrap;
    int            m_rem;

    logic [AW+IW+AW+1:0] obs_s, exp_s;
    assign obs_s = {bus.Mem_Addr, bus.Inst_Out, bus.Inst_PC, bus.Inst_Valid, bus.PC_Wrap};
    assign exp_s = {m_pc, m_ir, m_irpc, m_valid, m_wrap};

    task automatic model_edge();
        if (PC_Clr) begin
            m_pc = '0; m_ir = '0; m_irpc = '0; m_valid = 1'b0; m_wrap = 1'b0; m_rem = 0;
        end
`ifdef FETCH_JUMP_EN
        else if (bus.PC_Ld) begin
            m_pc = bus.Jmp_Addr; m_valid = 1'b0; m_rem = 0;
        end
`endif
        else if (m_rem == 2) begin
            m_rem = 1;
        end else if (m_rem == 1) begin
            m_ir    = 16'h0100 + 16'(m_pc);
            m_irpc  = m_pc;
            if (int'(m_pc) == (1 << AW) - 1) m_wrap = 1'b1;
            m_pc    = AW'((int'(m_pc) + 1) % (1 << AW));
            m_valid = 1'b1;
            m_rem   = 0;
        end else if (m_valid) begin
            if (bus.Inst_Ack) begin
                m_valid = 1'b0;
                if (bus.Fetch_En) m_rem = 2;
            end
        end else if (bus.Fetch_En) begin
            m_rem = 2;
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic fe, input logic ack, input logic ld,
                         input logic [AW-1:0] ja, input logic clr);
        bus.Fetch_En = fe; bus.Inst_Ack = ack; bus.PC_Ld = ld; bus.Jmp_Addr = ja; PC_Clr = clr;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 7'd0, 1'b1);
        cyc();
        PC_Clr = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b1, 7'd55, 1'b1);
        cyc();
        cyc();
        vec++;
        if (obs_s !== {7'd0, 16'h0000, 7'd0, 1'b0, 1'b0}) begin
            err++;
            $display("FAIL reset_state got=%h want=%h", obs_s, {7'd0, 16'h0000, 7'd0, 1'b0, 1'b0});
        end
        PC_Clr = 1'b0;
    endtask

    task automatic test_stream();
        int nv = 0;
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 7'd0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            cyc();
            vec++;
            if (obs_s !== exp_s) begin
                err++; $display("FAIL stream cyc=%0d got=%h want=%h", i, obs_s, exp_s);
            end
            if (bus.Inst_Valid === 1'b1) begin
                vec++;
                if (bus.Inst_Out !== 16'h0100 + 16'(nv) || bus.Inst_PC !== AW'(nv)) begin
                    err++;
                    $display("FAIL stream_inst n=%0d got=%h@%0d want=%h@%0d", nv, bus.Inst_Out,
                             bus.Inst_PC, 16'h0100 + 16'(nv), nv);
                end
                nv++;
            end
        end
        vec++;
        if (nv != 4 || bus.Mem_Addr !== 7'd4) begin
            err++; $display("FAIL stream_end valids=%0d addr=%0d want 4/4", nv, bus.Mem_Addr);
        end
    endtask

    task automatic test_hold();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 7'd0, 1'b0);
        for (int i = 0; i < 3; i++) cyc();
        for (int i = 0; i < 5; i++) begin
            cyc();
            vec++;
            if (bus.Inst_Out !== 16'h0100 || bus.Inst_Valid !== 1'b1 || bus.Mem_Addr !== 7'd1) begin
                err++;
                $display("FAIL hold cyc=%0d got=%h v=%b pc=%0d want 0100/1/1", i, bus.Inst_Out,
                         bus.Inst_Valid, bus.Mem_Addr);
            end
        end
        bus.Inst_Ack = 1'b1;
        cyc();
        bus.Inst_Ack = 1'b0;
        for (int i = 0; i < 10 && bus.Inst_Valid !== 1'b1; i++) cyc();
        vec++;
        if (bus.Inst_Valid !== 1'b1 || bus.Inst_Out !== 16'h0101 || obs_s !== exp_s) begin
            err++; $display("FAIL hold_next got=%h v=%b want 0101/1", bus.Inst_Out, bus.Inst_Valid);
        end
    endtask

    task automatic test_jump();
        logic [IW-1:0] w_ir;
        logic [AW-1:0] w_pc;
        logic          w_v;
`ifdef FETCH_JUMP_EN
        w_v = 1'b0; w_ir = 16'h0164; w_pc = 7'd100;
`else
        w_v = 1'b1; w_ir = 16'h0100; w_pc = 7'd0;
`endif
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 7'd0, 1'b0);
        for (int i = 0; i < 10 && m_rem != 1; i++) cyc();
        drive(1'b1, 1'b1, 1'b1, 7'd100, 1'b0);
        cyc();
        drive(1'b1, 1'b1, 1'b0, 7'd50, 1'b0);
        vec++;
        if (bus.Inst_Valid !== w_v || obs_s !== exp_s) begin
            err++; $display("FAIL jump_capture v=%b want=%b got=%h want=%h", bus.Inst_Valid, w_v, obs_s, exp_s);
        end
        for (int i = 0; i < 10 && bus.Inst_Valid !== 1'b1; i++) cyc();
        vec++;
        if (bus.Inst_Out !== w_ir || bus.Inst_PC !== w_pc || bus.Inst_Valid !== 1'b1) begin
            err++; $display("FAIL jump_next got=%h@%0d want=%h@%0d", bus.Inst_Out, bus.Inst_PC, w_ir, w_pc);
        end
    endtask

    task automatic test_wrap();
        int k;
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 7'd126, 1'b0);
        cyc();
        drive(1'b1, 1'b1, 1'b0, 7'd0, 1'b0);
        for (k = 0; k < 600 && !m_wrap; k++) begin
            cyc();
            if (obs_s !== exp_s) begin
                vec++; err++; $display("FAIL wrap_run cyc=%0d got=%h want=%h", k, obs_s, exp_s);
            end
        end
        vec++;
        if (k >= 600 || bus.PC_Wrap !== 1'b1 || bus.Inst_PC !== 7'd127 || bus.Mem_Addr !== 7'd0) begin
            err++; $display("FAIL wrap_set wrap=%b ipc=%0d pc=%0d want 1/127/0", bus.PC_Wrap, bus.Inst_PC, bus.Mem_Addr);
        end
        for (int i = 0; i < 9; i++) begin
            cyc();
            vec++;
            if (obs_s !== exp_s || bus.PC_Wrap !== 1'b1) begin
                err++; $display("FAIL wrap_sticky cyc=%0d got=%h want=%h", i, obs_s, exp_s);
            end
        end
    endtask

    task automatic test_clr_mid();
        int k;
        drive(1'b1, 1'b1, 1'b0, 7'd0, 1'b0);
        for (k = 0; k < 10 && m_rem != 2; k++) cyc();
        PC_Clr = 1'b1;
        cyc();
        drive(1'b0, 1'b1, 1'b0, 7'd0, 1'b0);
        vec++;
        if (k >= 10 || obs_s !== {7'd0, 16'h0000, 7'd0, 1'b0, 1'b0}) begin
            err++; $display("FAIL clr_mid got=%h want all zero", obs_s);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            vec++;
            if (bus.Inst_Valid !== 1'b0 || bus.Mem_Addr !== 7'd0 || obs_s !== exp_s) begin
                err++; $display("FAIL clr_idle cyc=%0d got=%h want=%h", i, obs_s, exp_s);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                  AW'($urandom), ($urandom_range(0, 39) == 0));
            cyc();
            vec++;
            if (obs_s !== exp_s) begin
                err++; $display("FAIL random cyc=%0d got=%h want=%h", i, obs_s, exp_s);
            end
        end
    endtask

    initial begin
        vec = 0; err = 0;
        m_pc = '0; m_ir = '0; m_irpc = '0; m_valid = 1'b0; m_wrap = 1'b0; m_rem = 0;
        drive(1'b0, 1'b0, 1'b0, 7'd0, 1'b1);
        test_reset();
        test_stream();
        test_hold();
        test_jump();
        test_wrap();
        test_clr_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
